// File: rtl/pipe_mux_n_if.sv
// Handshake bundle between an upstream producer, the pipe_mux_n skid mux and its consumer.
// Latency: none; this file only groups wires.
// Backpressure: in_ready / out_ready carry flow control in each direction.
interface pipe_mux_n_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err;
    logic [7:0]              err_cnt;
    logic                    err_clr;

    // Producer/consumer side: drives offers, flush, consume and error clear.
    modport master (
        output in, sel, in_valid, flush, out_ready, err_clr,
        input  in_ready, out, out_valid, err, err_cnt
    );

    // Mux side.
    modport slave (
        input  in, sel, in_valid, flush, out_ready, err_clr,
        output in_ready, out, out_valid, err, err_cnt
    );
endinterface

// File: rtl/pipe_mux_n.sv
// N:1 channel select at accept time into a 2-entry skid buffer (head drives out, skid behind).
// Latency: 1 cycle from accept into an empty buffer to out_valid; one transfer/cycle sustained.
// Backpressure: in_ready is registered (skid empty); out_ready never reaches in_ready combinationally.
module pipe_mux_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic        clk,
    input  logic        reset,
    pipe_mux_n_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] head_q, head_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             in_ready_q, in_ready_n;
    logic             err_q, err_n;
    logic [7:0]       err_cnt_q, err_cnt_n;
    logic [WIDTH-1:0] sel_dat;
    logic             sel_hit;
    logic             acc_in;
    logic             acc_out;

    // Pick channel sel from the flattened bus; a select with no matching channel yields zero data.
    always_comb begin
        sel_dat = '0;
        sel_hit = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                sel_dat = bus.in[k*WIDTH +: WIDTH];
                sel_hit = 1'b1;
            end
        end
    end

    // A flushed offer is dropped, so it is neither stored nor counted as an error.
    assign acc_in  = bus.in_valid & in_ready_q & ~bus.flush;
    assign acc_out = (state_q != EMPTY) & bus.out_ready;

    // Occupancy FSM and data movement; vacated registers are zeroed so out reads zero when idle.
    always_comb begin
        state_n = state_q;
        head_n  = head_q;
        skid_n  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc_in) begin
                    state_n = ONE;
                    head_n  = sel_dat;
                end
            end
            ONE: begin
                if (acc_in && acc_out) begin
                    head_n = sel_dat;
                end else if (acc_in) begin
                    state_n = FULL;
                    skid_n  = sel_dat;
                end else if (acc_out) begin
                    state_n = EMPTY;
                    head_n  = '0;
                end
            end
            FULL: begin
                if (acc_out) begin
                    state_n = ONE;
                    head_n  = skid_q;
                    skid_n  = '0;
                end
            end
            default: begin
                state_n = EMPTY;
                head_n  = '0;
                skid_n  = '0;
            end
        endcase
        if (bus.flush) begin
            state_n = EMPTY;
            head_n  = '0;
            skid_n  = '0;
        end
        in_ready_n = (state_n != FULL);
    end

    // Sticky error and saturating count of accepted out-of-range selects; clear has priority.
    always_comb begin
        err_n     = err_q;
        err_cnt_n = err_cnt_q;
        if (bus.err_clr) begin
            err_n     = 1'b0;
            err_cnt_n = 8'd0;
        end else if (acc_in && !sel_hit) begin
            err_n = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_n = err_cnt_q + 8'd1;
            end
        end
    end

    // State registers with synchronous active-low reset overriding everything else.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_n;
            head_q     <= head_n;
            skid_q     <= skid_n;
            in_ready_q <= in_ready_n;
            err_q      <= err_n;
            err_cnt_q  <= err_cnt_n;
        end
    end

    assign bus.out       = head_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.in_ready  = in_ready_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_pipe_mux_n.sv
// Randomized + directed bench for pipe_mux_n with a queue-based reference model.
// The driver updates the model; an independent monitor compares DUT outputs to the queue head.
// All DUT sampling happens on the falling edge or 1 time unit after the rising edge.
module tb_pipe_mux_n;
    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_mux_n_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

    pipe_mux_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] ch [NUM_IN];
    logic [WIDTH-1:0] exp_q [$];
    bit               exp_err = 1'b0;
    int               exp_cnt = 0;
    bit               mon_en  = 1'b0;
    int               n_acc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_pick(input int s);
        if (s < NUM_IN) return ch[s];
        return '0;
    endfunction

    // Monitor: compares the visible head against the model every cycle and retires consumed entries.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
                check("err", 32'(bus.err), 32'(exp_err));
                check("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
                if (exp_q.size() != 0) begin
                    check("out_data", bus.out, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end else begin
                    check("out_idle_zero", bus.out, 32'd0);
                end
            end
        end
    end

    // One clock of stimulus; the model is advanced after the monitor has seen this cycle.
    task automatic step(input logic r, input logic iv, input logic [1:0] s,
                        input logic ordy, input logic fl, input logic clr);
        bit rdy_m;
        bit acc;
        @(posedge clk);
        #1;
        rdy_m = (exp_q.size() < 2);
        if (mon_en) check("in_ready", 32'(bus.in_ready), 32'(rdy_m));
        reset = r;
        for (int k = 0; k < NUM_IN; k++) bus.in[k*WIDTH +: WIDTH] = ch[k];
        bus.sel       = s;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.err_clr   = clr;
        @(negedge clk);
        #1;
        if (!r) begin
            exp_q.delete();
            exp_err = 1'b0;
            exp_cnt = 0;
        end else begin
            acc = iv && rdy_m && !fl;
            if (fl) exp_q.delete();
            else if (acc) begin
                exp_q.push_back(ref_pick(int'(s)));
                n_acc++;
            end
            if (clr) begin
                exp_err = 1'b0;
                exp_cnt = 0;
            end else if (acc && int'(s) >= NUM_IN) begin
                exp_err = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end
        end
        mon_en = 1'b1;
    endtask

    initial begin
        int start;
        int iter;
        bus.in = '0; bus.sel = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.flush = 1'b0; bus.err_clr = 1'b0;
        for (int k = 0; k < NUM_IN; k++) ch[k] = '0;

        // Reset with junk on the inputs; monitor then checks the reset state.
        step(0, 1, 2'd1, 1, 1, 1);
        step(0, 1, 2'd0, 0, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0);

        // Basic select of channel 2, one-cycle latency.
        ch[0] = 32'h0000_0A0A; ch[1] = 32'h0000_0B0B; ch[2] = 32'hDEAD_BEEF;
        step(1, 1, 2'd2, 1, 0, 0);
        step(1, 0, 2'd0, 1, 0, 0);
        step(1, 0, 2'd0, 1, 0, 0);

        // Backpressure: fill both entries, offer a third while full, then drain in order.
        ch[0] = 32'h11; ch[1] = 32'h22; ch[2] = 32'h33;
        step(1, 1, 2'd0, 0, 0, 0);
        step(1, 1, 2'd1, 0, 0, 0);
        step(1, 1, 2'd2, 0, 0, 0);
        step(1, 1, 2'd2, 0, 0, 0);
        step(1, 0, 2'd0, 1, 0, 0);
        step(1, 0, 2'd0, 1, 0, 0);
        step(1, 0, 2'd0, 1, 0, 0);

        // Out-of-range select stores zero and counts; 300 more saturate; clear resets.
        step(1, 1, 2'd3, 1, 0, 0);
        step(1, 0, 2'd0, 1, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 1, 2'd3, 1, 0, 0);
        step(1, 0, 2'd0, 1, 0, 1);
        step(1, 1, 2'd3, 1, 0, 1);
        step(1, 1, 2'd3, 0, 0, 0);
        step(1, 0, 2'd0, 1, 0, 0);

        // Flush from FULL with a same-cycle offer of 0x33 that must be dropped.
        step(1, 1, 2'd0, 0, 0, 0);
        step(1, 1, 2'd1, 0, 0, 0);
        step(1, 1, 2'd2, 0, 1, 0);
        step(1, 0, 2'd0, 1, 0, 0);
        // Flush in ONE with a same-cycle consume, and a flushed out-of-range offer.
        step(1, 1, 2'd1, 0, 0, 0);
        step(1, 1, 2'd3, 1, 1, 0);
        step(1, 0, 2'd0, 1, 0, 0);

        // Reset mid-operation from FULL with the error flag set.
        step(1, 1, 2'd3, 0, 0, 0);
        step(1, 1, 2'd0, 0, 0, 0);
        step(0, 1, 2'd1, 1, 1, 1);
        step(1, 1, 2'd1, 1, 0, 0);
        step(1, 0, 2'd0, 1, 0, 0);

        // Random streaming until 1000 accepts, with rare flush, clear and reset.
        start = n_acc;
        iter  = 0;
        while ((n_acc - start) < 1000 && iter < 6000) begin
            for (int k = 0; k < NUM_IN; k++) ch[k] = $urandom;
            step(logic'($urandom_range(0, 299) != 0),
                 logic'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 2) != 0),
                 logic'($urandom_range(0, 39) == 0),
                 logic'($urandom_range(0, 49) == 0));
            iter++;
        end
        if ((n_acc - start) < 1000) begin
            checks++;
            errors++;
            $display("FAIL random_budget: got %0d accepts required 1000", n_acc - start);
        end

        // Drain; the monitor confirms the buffer empties.
        for (int i = 0; i < 4; i++) step(1, 0, 2'd0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
